// File: rtl/car_sensor_emulator_if.sv
// car_sensor_emulator_if: request handshake, sensor lines and pass counters of the car emulator.
interface car_sensor_emulator_if;
   logic       req_enter;
   logic       req_exit;
   logic       ready;
   logic       a;
   logic       b;
   logic       done;
   logic       conflict;
   logic [7:0] n_enter;
   logic [7:0] n_exit;
   modport master (
      output req_enter, req_exit,
      input  ready, a, b, done, conflict, n_enter, n_exit
   );
   modport slave (
      input  req_enter, req_exit,
      output ready, a, b, done, conflict, n_enter, n_exit
   );
endinterface

// File: rtl/car_sensor_emulator.sv
// car_sensor_emulator: plays one Gray-coded car passage on the a/b photo-sensor lines per accepted request.
module car_sensor_emulator #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2
) (
   input logic             clk,
   input logic             reset,
   car_sensor_emulator_if.slave bus
);
   localparam int MAX_LEN = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int W = $clog2(MAX_LEN + 1);
   localparam logic [W-1:0] H_LAST = W'(HOLD_CYCLES - 1);
   localparam logic [W-1:0] G_LAST = W'(GAP_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;
   state_t state, state_nx;
   logic [W-1:0] cnt, cnt_nx;
   logic dir, dir_nx, go, phase_end;
   logic a_nx, b_nx, ready_nx, done_nx, conflict_nx;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         dir          <= 1'b0;
         bus.a        <= 1'b0;
         bus.b        <= 1'b0;
         bus.ready    <= 1'b1;
         bus.done     <= 1'b0;
         bus.conflict <= 1'b0;
         bus.n_enter  <= '0;
         bus.n_exit   <= '0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         dir          <= dir_nx;
         bus.a        <= a_nx;
         bus.b        <= b_nx;
         bus.ready    <= ready_nx;
         bus.done     <= done_nx;
         bus.conflict <= conflict_nx;
         if (done_nx && !dir) bus.n_enter <= bus.n_enter + 8'd1;
         if (done_nx && dir) bus.n_exit <= bus.n_exit + 8'd1;
      end
   end
   always_comb begin
      go        = bus.req_enter ^ bus.req_exit;
      phase_end = (state == GAP) ? (cnt == G_LAST) : (cnt == H_LAST);
      state_nx  = (state == IDLE) ? (go ? PH1 : IDLE) :
                  !phase_end      ? state :
                  (state == GAP)  ? IDLE : state_t'(state + 3'd1);
      cnt_nx    = (state == IDLE || phase_end) ? '0 : cnt + W'(1);
      dir_nx    = (state == IDLE && go) ? bus.req_exit : dir;
   end
   // Outputs are computed from the next state so a/b change on the very edge the phase changes.
   always_comb begin
      a_nx        = (state_nx == PH2) || (state_nx == PH1 && !dir_nx) || (state_nx == PH3 && dir_nx);
      b_nx        = (state_nx == PH2) || (state_nx == PH1 && dir_nx) || (state_nx == PH3 && !dir_nx);
      ready_nx    = state_nx == IDLE;
      done_nx     = state == PH3 && state_nx == GAP;
      conflict_nx = state == IDLE && bus.req_enter && bus.req_exit;
   end
endmodule

// File: tb/tb_car_sensor_emulator.sv
// tb_car_sensor_emulator: random and directed request traffic checked against a pass-timeline model.
module tb_car_sensor_emulator;
   localparam int H = 2;
   localparam int G = 1;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_vec = 0;
   int n_bad = 0;
   int t = -1;
   bit mdir = 1'b0;
   bit mconf = 1'b0;
   logic [7:0] me = '0, mx = '0;
   car_sensor_emulator_if bus ();
   car_sensor_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic model_reset();
      t = -1;
      mconf = 1'b0;
      me = '0;
      mx = '0;
   endtask
   // t counts clocks since the accept edge; -1 means idle.
   task automatic model_edge(input bit re, input bit rx);
      mconf = (t < 0) && re && rx;
      if (t < 0) begin
         if (re ^ rx) begin
            t = 0;
            mdir = rx;
         end
      end else begin
         t++;
         if (t == 3*H) begin
            if (mdir) mx++;
            else me++;
         end
         if (t == 3*H + G) t = -1;
      end
   endtask
   task automatic compare();
      logic [1:0] ab;
      int p;
      p = (t < 0) ? 3 : t / H;
      ab = (p >= 3) ? 2'b00 : (p == 1) ? 2'b11 :
           (p == 0) ? (mdir ? 2'b01 : 2'b10) : (mdir ? 2'b10 : 2'b01);
      check("ab", {6'd0, bus.a, bus.b}, {6'd0, ab});
      check("ready", {7'd0, bus.ready}, {7'd0, t < 0});
      check("done", {7'd0, bus.done}, {7'd0, t == 3*H});
      check("conflict", {7'd0, bus.conflict}, {7'd0, mconf});
      check("n_enter", bus.n_enter, me);
      check("n_exit", bus.n_exit, mx);
   endtask
   task automatic cyc(input bit re, input bit rx);
      @(negedge clk);
      bus.req_enter = re;
      bus.req_exit = rx;
      @(posedge clk);
      model_edge(re, rx);
      #1 compare();
   endtask
   task automatic do_reset();
      @(negedge clk);
      bus.req_enter = 1'b0;
      bus.req_exit = 1'b0;
      reset = 1'b1;
      #1 model_reset();
      compare();
      @(negedge clk) reset = 1'b0;
   endtask
   initial begin
      int r;
      bus.req_enter = 1'b0;
      bus.req_exit = 1'b0;
      repeat (2) @(posedge clk);
      #1 compare();
      @(negedge clk) reset = 1'b0;
      cyc(1, 0);
      repeat (8) cyc(0, 0);
      cyc(0, 1);
      repeat (8) cyc(0, 0);
      cyc(1, 1);
      cyc(1, 0);
      repeat (9) cyc(0, 0);
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 9));
         cyc(r >= 4 && r <= 6 || r == 9, r >= 7);
      end
      repeat (10) cyc(0, 0);
      cyc(1, 0);
      while (t != 2*H) cyc(0, 0);
      #2 reset = 1'b1;
      #1 model_reset();
      compare();
      check("async_ab", {6'd0, bus.a, bus.b}, 8'd0);
      @(negedge clk) reset = 1'b0;
      do_reset();
      repeat (2047) cyc(1, 0);
      check("wrap", bus.n_enter, 8'd0);
      repeat (3) cyc(0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
